// File: rtl/usrt_apb_master_pkg.sv
// Shared definitions for the USRT APB initiator: state encoding, default
// bus widths and the wait-counter sizing helper.
package usrt_apb_master_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETUP  = 2'd1,
    ACCESS = 2'd2,
    RESP   = 2'd3
  } apb_state_e;

  localparam int unsigned USRT_ADDR_W = 32;
  localparam int unsigned USRT_DATA_W = 8;

  // Counter width for a wait limit; a disabled limit (0) still needs one bit.
  function automatic int unsigned wait_cnt_w(input int unsigned timeout);
    return (timeout == 0) ? 1 : $clog2(timeout + 1);
  endfunction

endpackage

// File: rtl/usrt_apb_master_wait_timer.sv
// Clearable saturating wait-state counter with an expiry compare.
module wait_timer
  import usrt_apb_master_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic expired_o
);

  localparam int unsigned CW = wait_cnt_w(TIMEOUT);
  localparam logic [CW-1:0] CNT_MAX = '1;
  localparam logic [CW-1:0] LAST = CW'((TIMEOUT == 0) ? 0 : TIMEOUT - 1);

  logic [CW-1:0] cnt_q;

  // Count wait cycles, saturating at the top of the counter range.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (inc_i && (cnt_q != CNT_MAX)) begin
      cnt_q <= cnt_q + 1'b1;
    end
  end

  // Expiry fires on the edge whose increment would make the count reach
  // TIMEOUT, so exactly TIMEOUT wait cycles are tolerated.
  assign expired_o = (TIMEOUT != 0) && inc_i && (cnt_q == LAST);

endmodule

// File: rtl/usrt_apb_master.sv
// APB initiator driving the USRT bridge from a command/response interface.
module usrt_apb_master
  import usrt_apb_master_pkg::*;
#(
  parameter int unsigned ADDR_W  = USRT_ADDR_W,
  parameter int unsigned DATA_W  = USRT_DATA_W,
  parameter int unsigned TIMEOUT = 255
) (
  input  logic              pClk,
  input  logic              pReset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic              cmd_write,
  input  logic [ADDR_W-1:0] cmd_addr,
  input  logic [DATA_W-1:0] cmd_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              rsp_err,
  output logic              pSelect,
  output logic              pEnable,
  output logic              pWrite,
  output logic [ADDR_W-1:0] pAddress,
  output logic [DATA_W-1:0] pWData,
  input  logic [DATA_W-1:0] pRData,
  input  logic              pReady,
  input  logic              pSlvErr
);

  apb_state_e        state_q;
  logic              psel_q;
  logic              pen_q;
  logic              pwrite_q;
  logic [ADDR_W-1:0] paddr_q;
  logic [DATA_W-1:0] pwdata_q;
  logic              cmd_ready_q;
  logic              rsp_valid_q;
  logic [DATA_W-1:0] rsp_rdata_q;
  logic              rsp_err_q;

  logic              tmr_clr;
  logic              tmr_inc;
  logic              tmr_expired;

  assign tmr_clr = (state_q == SETUP);
  assign tmr_inc = (state_q == ACCESS) && !pReady;

  wait_timer #(
    .TIMEOUT (TIMEOUT)
  ) u_wait_timer (
    .clk_i     (pClk),
    .rst_ni    (pReset),
    .clr_i     (tmr_clr),
    .inc_i     (tmr_inc),
    .expired_o (tmr_expired)
  );

  // Transfer sequencer; the APB address/data/direction registers double as
  // the command holding registers and are cleared once the bus goes idle.
  always_ff @(posedge pClk) begin
    if (!pReset) begin
      state_q     <= IDLE;
      psel_q      <= 1'b0;
      pen_q       <= 1'b0;
      pwrite_q    <= 1'b0;
      paddr_q     <= '0;
      pwdata_q    <= '0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= '0;
      rsp_err_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cmd_valid && cmd_ready_q) begin
            state_q     <= SETUP;
            psel_q      <= 1'b1;
            pwrite_q    <= cmd_write;
            paddr_q     <= cmd_addr;
            pwdata_q    <= cmd_wdata;
            cmd_ready_q <= 1'b0;
          end
        end
        SETUP: begin
          state_q <= ACCESS;
          pen_q   <= 1'b1;
        end
        ACCESS: begin
          if (pReady || tmr_expired) begin
            state_q     <= RESP;
            psel_q      <= 1'b0;
            pen_q       <= 1'b0;
            pwrite_q    <= 1'b0;
            paddr_q     <= '0;
            pwdata_q    <= '0;
            rsp_valid_q <= 1'b1;
            if (pReady) begin
              rsp_err_q   <= pSlvErr;
              rsp_rdata_q <= (!pwrite_q && !pSlvErr) ? pRData : '0;
            end else begin
              rsp_err_q   <= 1'b1;
              rsp_rdata_q <= '0;
            end
          end
        end
        RESP: begin
          if (rsp_ready) begin
            state_q     <= IDLE;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
            rsp_err_q   <= 1'b0;
            cmd_ready_q <= 1'b1;
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_rdata = rsp_rdata_q;
  assign rsp_err   = rsp_err_q;
  assign pSelect   = psel_q;
  assign pEnable   = pen_q;
  assign pWrite    = pwrite_q;
  assign pAddress  = paddr_q;
  assign pWData    = pwdata_q;

endmodule
